// File: rtl/sc_turnarbiter_jug_pkg.sv
// sc_turnarbiter_jug_pkg: shared state, shift and turn encodings for the turn arbiter.
package sc_turnarbiter_jug_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_TURN_J1 = 3'd2,
        ST_MOVE_J1 = 3'd3,
        ST_TURN_J2 = 3'd4,
        ST_MOVE_J2 = 3'd5
    } state_t;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;
    localparam logic [1:0] TURN_NONE   = 2'b00;
    localparam logic [1:0] TURN_J1     = 2'b01;
    localparam logic [1:0] TURN_J2     = 2'b10;
    function automatic logic dir_valid(input logic [1:0] d);
        return (d == SHIFT_LEFT) || (d == SHIFT_RIGHT);
    endfunction
endpackage

// File: rtl/sc_fall_detect.sv
// sc_fall_detect: registered one-cycle pulse on a 1->0 transition of an active-low level.
module sc_fall_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic fall
);
    logic prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
            fall <= 1'b0;
        end else begin
            prev <= level;
            fall <= prev & ~level;
        end
    end
endmodule

// File: rtl/sc_turnarbiter_jug.sv
// sc_turnarbiter_jug: alternating-turn scheduler sharing the board shift datapath between two players.
module sc_turnarbiter_jug
    import sc_turnarbiter_jug_pkg::*;
#(
    parameter int MOVES_PER_TURN = 3,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int TIMEOUT_W      = 26
) (
    input  logic       SC_TURNARB_CLOCK_50,
    input  logic       SC_TURNARB_RESET_InLow,
    input  logic       SC_TURNARB_startButton_InLow,
    input  logic       SC_TURNARB_jug1Req_InLow,
    input  logic [1:0] SC_TURNARB_jug1Dir_In,
    input  logic       SC_TURNARB_jug2Req_InLow,
    input  logic [1:0] SC_TURNARB_jug2Dir_In,
    output logic       SC_TURNARB_clear_OutLow,
    output logic [1:0] SC_TURNARB_shiftselection_Out,
    output logic [1:0] SC_TURNARB_turn_Out,
    output logic [3:0] SC_TURNARB_moveCount_Out,
    output logic       SC_TURNARB_timeout_Out
);
    localparam logic [TIMEOUT_W-1:0] T_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]           M_LAST = 4'(MOVES_PER_TURN);

    state_t               state;
    logic                 clear_n;
    logic [1:0]           shift;
    logic [1:0]           turn;
    logic [3:0]           count;
    logic [TIMEOUT_W-1:0] timer;
    logic                 timeout;
    logic                 fall1;
    logic                 fall2;
    logic                 owner2;
    logic                 req;
    logic [1:0]           req_dir;

    sc_fall_detect u_fall1 (
        .clk   (SC_TURNARB_CLOCK_50),
        .rst_n (SC_TURNARB_RESET_InLow),
        .level (SC_TURNARB_jug1Req_InLow),
        .fall  (fall1)
    );

    sc_fall_detect u_fall2 (
        .clk   (SC_TURNARB_CLOCK_50),
        .rst_n (SC_TURNARB_RESET_InLow),
        .level (SC_TURNARB_jug2Req_InLow),
        .fall  (fall2)
    );

    // Only the current owner's edge is ever looked at; the other player's edge is dropped.
    assign owner2  = (state == ST_TURN_J2) || (state == ST_MOVE_J2);
    assign req_dir = owner2 ? SC_TURNARB_jug2Dir_In : SC_TURNARB_jug1Dir_In;
    assign req     = (owner2 ? fall2 : fall1) && dir_valid(req_dir);

    always_ff @(posedge SC_TURNARB_CLOCK_50 or negedge SC_TURNARB_RESET_InLow) begin
        if (!SC_TURNARB_RESET_InLow) begin
            state   <= ST_IDLE;
            clear_n <= 1'b1;
            shift   <= SHIFT_HOLD;
            turn    <= TURN_NONE;
            count   <= 4'd0;
            timer   <= '0;
            timeout <= 1'b0;
        end else begin
            clear_n <= 1'b1;
            shift   <= SHIFT_HOLD;
            timeout <= 1'b0;
            if (!SC_TURNARB_startButton_InLow) begin
                state   <= ST_CLEAR;
                clear_n <= 1'b0;
                turn    <= TURN_NONE;
                count   <= 4'd0;
                timer   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        turn <= TURN_NONE;
                    end
                    ST_CLEAR: begin
                        state <= ST_TURN_J1;
                        turn  <= TURN_J1;
                    end
                    ST_TURN_J1, ST_TURN_J2: begin
                        if (req) begin
                            state <= owner2 ? ST_MOVE_J2 : ST_MOVE_J1;
                            shift <= req_dir;
                            count <= count + 4'd1;
                            timer <= '0;
                        end else if (timer == T_LAST) begin
                            state   <= owner2 ? ST_TURN_J1 : ST_TURN_J2;
                            turn    <= owner2 ? TURN_J1 : TURN_J2;
                            timeout <= 1'b1;
                            count   <= 4'd0;
                            timer   <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_MOVE_J1, ST_MOVE_J2: begin
                        timer <= '0;
                        if (count >= M_LAST) begin
                            state <= owner2 ? ST_TURN_J1 : ST_TURN_J2;
                            turn  <= owner2 ? TURN_J1 : TURN_J2;
                            count <= 4'd0;
                        end else begin
                            state <= owner2 ? ST_TURN_J2 : ST_TURN_J1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        turn  <= TURN_NONE;
                        count <= 4'd0;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

    assign SC_TURNARB_clear_OutLow       = clear_n;
    assign SC_TURNARB_shiftselection_Out = shift;
    assign SC_TURNARB_turn_Out           = turn;
    assign SC_TURNARB_moveCount_Out      = count;
    assign SC_TURNARB_timeout_Out        = timeout;
endmodule

// File: tb/tb_sc_turnarbiter_jug.sv
// tb_sc_turnarbiter_jug: vector table plus hand sequences for turn, quota, timeout, restart and reset.
module tb_sc_turnarbiter_jug;
    typedef struct packed {
        logic       start_n;
        logic       r1;
        logic [1:0] d1;
        logic       r2;
        logic [1:0] d2;
        logic       clr;
        logic [1:0] sh;
        logic [1:0] turn;
        logic [3:0] cnt;
        logic       to;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_n = 1'b1;
    logic       r1 = 1'b1;
    logic       r2 = 1'b1;
    logic [1:0] d1 = 2'b00;
    logic [1:0] d2 = 2'b00;
    logic       clr;
    logic [1:0] sh;
    logic [1:0] turn;
    logic [3:0] cnt;
    logic       to;
    int         errors = 0;
    int         checks = 0;
    vec_t       exp_q[$];
    vec_t       tbl[8];

    always #5 clk = ~clk;

    sc_turnarbiter_jug #(
        .MOVES_PER_TURN (2),
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_W      (5)
    ) dut (
        .SC_TURNARB_CLOCK_50           (clk),
        .SC_TURNARB_RESET_InLow        (rst_n),
        .SC_TURNARB_startButton_InLow  (start_n),
        .SC_TURNARB_jug1Req_InLow      (r1),
        .SC_TURNARB_jug1Dir_In         (d1),
        .SC_TURNARB_jug2Req_InLow      (r2),
        .SC_TURNARB_jug2Dir_In         (d2),
        .SC_TURNARB_clear_OutLow       (clr),
        .SC_TURNARB_shiftselection_Out (sh),
        .SC_TURNARB_turn_Out           (turn),
        .SC_TURNARB_moveCount_Out      (cnt),
        .SC_TURNARB_timeout_Out        (to)
    );

    function automatic vec_t mk(logic s, logic a1, logic [1:0] a2, logic b1, logic [1:0] b2,
                                logic e_clr, logic [1:0] e_sh, logic [1:0] e_turn,
                                logic [3:0] e_cnt, logic e_to);
        return {s, a1, a2, b1, b2, e_clr, e_sh, e_turn, e_cnt, e_to};
    endfunction

    task automatic cmp(string name, logic [3:0] act, logic [3:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic check_out(string tag, int idx, vec_t e);
        cmp($sformatf("%s[%0d].clear", tag, idx), {3'b0, clr}, {3'b0, e.clr});
        cmp($sformatf("%s[%0d].shift", tag, idx), {2'b0, sh}, {2'b0, e.sh});
        cmp($sformatf("%s[%0d].turn", tag, idx), {2'b0, turn}, {2'b0, e.turn});
        cmp($sformatf("%s[%0d].count", tag, idx), cnt, e.cnt);
        cmp($sformatf("%s[%0d].timeout", tag, idx), {3'b0, to}, {3'b0, e.to});
    endtask

    task automatic apply(string tag, int idx, vec_t v);
        vec_t e;
        start_n = v.start_n;
        r1 = v.r1;
        d1 = v.d1;
        r2 = v.r2;
        d2 = v.d2;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_out(tag, idx, e);
    endtask

    initial begin
        // start, two P1 moves (left then right) ending the turn; P2 edge during P1's turn is ignored
        tbl[0] = mk(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 2'd3, 2'd0, 4'd0, 1'b0);
        tbl[1] = mk(1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 2'd3, 2'd1, 4'd0, 1'b0);
        tbl[2] = mk(1'b1, 1'b0, 2'd1, 1'b1, 2'd0, 1'b1, 2'd3, 2'd1, 4'd0, 1'b0);
        tbl[3] = mk(1'b1, 1'b0, 2'd1, 1'b1, 2'd0, 1'b1, 2'd1, 2'd1, 4'd1, 1'b0);
        tbl[4] = mk(1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 1'b1, 2'd3, 2'd1, 4'd1, 1'b0);
        tbl[5] = mk(1'b1, 1'b0, 2'd2, 1'b0, 2'd1, 1'b1, 2'd3, 2'd1, 4'd1, 1'b0);
        tbl[6] = mk(1'b1, 1'b0, 2'd2, 1'b0, 2'd1, 1'b1, 2'd2, 2'd1, 4'd2, 1'b0);
        tbl[7] = mk(1'b1, 1'b1, 2'd2, 1'b0, 2'd1, 1'b1, 2'd3, 2'd2, 4'd0, 1'b0);

        repeat (2) @(posedge clk);
        #3;
        check_out("reset", 0, mk(1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 2'd3, 2'd0, 4'd0, 1'b0));
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) apply("p1_turn", i, tbl[i]);

        // P2 held low (no edge), P1 edge out of turn: forced pass on the 16th cycle
        for (int i = 1; i <= 20; i++)
            apply("timeout", i, mk(1'b1, (i == 3) ? 1'b0 : 1'b1, 2'd1, 1'b0, 2'd1,
                                   1'b1, 2'd3, (i >= 16) ? 2'd1 : 2'd2, 4'd0, (i == 16)));

        // restart, let P1 time out, then both players' edges land on P2's terminal count
        apply("collide_start", 0, mk(1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 1'b0, 2'd3, 2'd0, 4'd0, 1'b0));
        apply("collide_start", 1, mk(1'b1, 1'b1, 2'd1, 1'b1, 2'd2, 1'b1, 2'd3, 2'd1, 4'd0, 1'b0));
        for (int k = 1; k <= 16; k++)
            apply("p1_idle", k, mk(1'b1, 1'b1, 2'd1, 1'b1, 2'd2,
                                   1'b1, 2'd3, (k == 16) ? 2'd2 : 2'd1, 4'd0, (k == 16)));
        for (int j = 1; j <= 17; j++) begin
            logic lo;
            lo = (j == 15 || j == 16) ? 1'b0 : 1'b1;
            apply("collide", j, mk(1'b1, lo, 2'd1, lo, 2'd2, 1'b1,
                                   (j == 16) ? 2'd2 : 2'd3, 2'd2, (j >= 16) ? 4'd1 : 4'd0, 1'b0));
        end

        // start pressed during MOVE_J2
        apply("move_start", 0, mk(1'b1, 1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 2'd3, 2'd2, 4'd1, 1'b0));
        apply("move_start", 1, mk(1'b1, 1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 2'd1, 2'd2, 4'd2, 1'b0));
        apply("move_start", 2, mk(1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 2'd3, 2'd0, 4'd0, 1'b0));
        apply("move_start", 3, mk(1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 2'd3, 2'd1, 4'd0, 1'b0));

        // asynchronous reset in the middle of MOVE_J1
        apply("rst_move", 0, mk(1'b1, 1'b0, 2'd2, 1'b1, 2'd1, 1'b1, 2'd3, 2'd1, 4'd0, 1'b0));
        apply("rst_move", 1, mk(1'b1, 1'b0, 2'd2, 1'b1, 2'd1, 1'b1, 2'd2, 2'd1, 4'd1, 1'b0));
        #2 rst_n = 1'b0;
        #1 check_out("async_rst", 0, mk(1'b1, 1'b0, 2'd2, 1'b1, 2'd1, 1'b1, 2'd3, 2'd0, 4'd0, 1'b0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int z = 0; z < 4; z++)
            apply("idle_req", z, mk(1'b1, (z == 1) ? 1'b1 : 1'b0, 2'd1, 1'b1, 2'd1,
                                    1'b1, 2'd3, 2'd0, 4'd0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sc_turnarbiter_jug.md
Name: sc_turnarbiter_jug

Overview:
- Turn scheduler that shares the single board shift datapath (shift-selection code plus clear strobe) between player 1 and player 2.
- Player request inputs come from debounced button logic; outputs drive the shared shifter/register directly.
- Enforces alternating turns, a per-turn move quota and a per-turn inactivity timeout.

Parameters:
- MOVES_PER_TURN, 3: moves accepted before the turn passes (1..15).
- TIMEOUT_CYCLES, 50000000: idle cycles in a turn before a forced pass (1 s at 50 MHz).
- TIMEOUT_W, 26: timeout counter width; 2^TIMEOUT_W must be >= TIMEOUT_CYCLES.

Ports:
- SC_TURNARB_CLOCK_50  in  1  system clock
- SC_TURNARB_RESET_InLow  in  1  async active-low reset
- SC_TURNARB_startButton_InLow  in  1  start/restart game
- SC_TURNARB_jug1Req_InLow  in  1  player-1 move request (level)
- SC_TURNARB_jug1Dir_In  in  2  player-1 move code: 01 left, 10 right
- SC_TURNARB_jug2Req_InLow  in  1  player-2 move request (level)
- SC_TURNARB_jug2Dir_In  in  2  player-2 move code
- SC_TURNARB_clear_OutLow  out  1  shared-datapath clear strobe
- SC_TURNARB_shiftselection_Out  out  2  shared shifter code (11 = hold)
- SC_TURNARB_turn_Out  out  2  01 player 1, 10 player 2, 00 idle
- SC_TURNARB_moveCount_Out  out  4  moves taken in current turn
- SC_TURNARB_timeout_Out  out  1  one-cycle pulse on forced pass

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset state: IDLE. Output reset values: clear_OutLow=1, shiftselection=11, turn=00, moveCount=0, timeout=0. Edge-detect history registers reset to 1.
- Request acceptance:
  - Only a falling edge of reqX_InLow (previous sample 1, current 0) counts as a request.
  - A held-low request never repeats.
  - A request whose dir is 00 or 11 is ignored.
- FSM states:
  - IDLE: all outputs at idle values. On start low -> CLEAR.
  - CLEAR: clear_OutLow=0 for exactly one cycle; moveCount=0; timer=0. Next state -> TURN_J1.
  - TURN_J1 / TURN_J2:
    - turn=01 / 10; timer increments each cycle.
    - Valid owner request edge: latch dir, -> MOVE_Jx.
    - Timer reaching TIMEOUT_CYCLES-1: pulse timeout, clear moveCount and timer, -> other player's TURN.
    - Requests from the non-owner are ignored and not queued.
  - MOVE_J1 / MOVE_J2:
    - shiftselection = latched dir for exactly this one cycle; moveCount increments; timer clears.
    - If the new count equals MOVES_PER_TURN: clear moveCount, -> other player's TURN.
    - Otherwise: -> same TURN.
- Latency: request edge sampled at clock N -> shift code visible for the cycle following edge N+1. One move at most every 2 cycles.
- In every state except MOVE, shiftselection=11.
- Priorities:
  - Start low in any non-IDLE state -> CLEAR; this restarts the game and overrides requests and timeout.
  - Owner request and timeout in the same cycle: the request wins and no timeout pulse is issued.
  - Both players' edges in the same cycle: only the owner's edge is used.
- Asynchronous reset mid-move aborts immediately to IDLE; no partial shift code appears after reset assertion.
- Illegal or unencoded state -> IDLE with idle outputs.
- Width rules: timer saturates at terminal count and is never left to wrap. moveCount never exceeds MOVES_PER_TURN.

Decomposition:
- Shared package contains:
  - State encodings: IDLE, CLEAR, TURN_J1, MOVE_J1, TURN_J2, MOVE_J2.
  - Shift codes: SHIFT_LEFT=01, SHIFT_RIGHT=10, SHIFT_HOLD=11.
  - Turn codes: TURN_NONE=00, TURN_J1=01, TURN_J2=10.
- Sub-module: sc_fall_detect (1-bit falling-edge detector with async active-low reset), instanced once per player request.
- Timer and FSM stay in this block.

Test Plan (MOVES_PER_TURN=2, TIMEOUT_CYCLES=16 unless noted):
- Reset low, then start pulse -> clear_OutLow=0 one cycle, then turn=01, shiftselection=11, moveCount=0.
- P1 two edges with dir 01 then 10 -> shiftselection 01 then 10, each for one cycle; moveCount 1 then 0; turn becomes 10 after the second move.
- Turn=10, P1 edge dir 01 and P2 held low for 20 cycles with no new edge -> no shift output; timeout pulse at cycle 16; turn=01.
- P2 edge on the same cycle the timer hits terminal count -> shiftselection=dir for one cycle; no timeout pulse; moveCount=1.
- Start pressed while in MOVE_J2 -> next cycle CLEAR (clear_OutLow=0), then turn=01, moveCount=0.
- Reset asserted mid-MOVE_J1 -> outputs return to reset values asynchronously; FSM in IDLE after release; a req edge with no start produces no output.
